// File: rtl/meteor_spawn_ctrl_if.sv
// rtl/meteor_spawn_ctrl_if.sv - spawn record handshake bundle
interface meteor_spawn_ctrl_if;
  logic       spawn_valid;
  logic       spawn_ready;
  logic [9:0] spawn_x;
  logic [2:0] spawn_xspeed;
  logic [2:0] spawn_yspeed;
  logic       spawn_sign;

  modport master (
    output spawn_valid, spawn_x, spawn_xspeed, spawn_yspeed, spawn_sign,
    input  spawn_ready
  );

  modport slave (
    input  spawn_valid, spawn_x, spawn_xspeed, spawn_yspeed, spawn_sign,
    output spawn_ready
  );
endinterface

// File: rtl/meteor_spawn_ctrl.sv
// rtl/meteor_spawn_ctrl.sv - frame-paced random meteor spawner with valid/ready offer
module meteor_spawn_ctrl #(
  parameter int SPAWN_PERIOD = 4,
  parameter int X_MAX        = 639
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                frame_Clk,
  input  logic                enable,
  input  logic                random_bit,
  meteor_spawn_ctrl_if.master spawn,
  output logic [7:0]          spawn_count,
  output logic [7:0]          miss_count
);

  typedef enum logic [1:0] {IDLE, COLLECT, ARMED, OFFER} state_t;

  localparam logic [3:0] DUE_AT = 4'(SPAWN_PERIOD - 1);
  localparam logic [9:0] XM     = 10'(X_MAX);
  localparam logic [9:0] XWRAP  = 10'(X_MAX + 1);

  state_t      state, next_state;
  logic [1:0]  rst_sync;
  logic        rst_int_n;
  logic [2:0]  frame_sync;
  logic        frame_tick;
  logic [3:0]  div_cnt;
  logic        due;
  logic [16:0] sr;
  logic [4:0]  bit_cnt;
  logic        do_shift, do_latch, do_accept, do_clr, do_miss;
  logic [9:0]  raw, x_map;
  logic [2:0]  xs_map, ys_map;

  // Assertion reaches every flop at once; release is retimed to Clk.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  always_ff @(posedge Clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      frame_sync <= 3'b000;
      frame_tick <= 1'b0;
    end else begin
      frame_sync <= {frame_sync[1:0], frame_Clk};
      frame_tick <= frame_sync[1] & ~frame_sync[2];
    end
  end

  assign due = frame_tick & enable & (div_cnt == DUE_AT);

  always_ff @(posedge Clk or negedge rst_int_n) begin
    if (!rst_int_n)      div_cnt <= '0;
    else if (!enable)    div_cnt <= '0;
    else if (frame_tick) div_cnt <= due ? 4'd0 : div_cnt + 4'd1;
  end

  always_ff @(posedge Clk or negedge rst_int_n) begin
    if (!rst_int_n) state <= IDLE;
    else            state <= next_state;
  end

  always_comb begin
    next_state = state;
    do_shift   = 1'b0;
    do_latch   = 1'b0;
    do_accept  = 1'b0;
    do_clr     = 1'b0;
    unique case (state)
      IDLE: if (enable) next_state = COLLECT;
      COLLECT: begin
        if (!enable) begin
          next_state = IDLE;
          do_clr     = 1'b1;
        end else begin
          do_shift = 1'b1;
          if (bit_cnt == 5'd16) next_state = ARMED;
        end
      end
      ARMED: begin
        if (!enable) begin
          next_state = IDLE;
          do_clr     = 1'b1;
        end else if (due) begin
          next_state = OFFER;
          do_latch   = 1'b1;
        end
      end
      OFFER: begin
        if (spawn.spawn_ready) begin
          do_accept  = 1'b1;
          do_clr     = 1'b1;
          next_state = enable ? COLLECT : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    do_miss = due & ((state == COLLECT) | (state == OFFER));
  end

  assign raw    = sr[16:7];
  assign x_map  = (raw > XM) ? raw - XWRAP : raw;
  assign xs_map = (sr[6:4] == 3'd0) ? 3'd1 : sr[6:4];
  assign ys_map = (sr[3:1] == 3'd0) ? 3'd1 : sr[3:1];

  always_ff @(posedge Clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sr                 <= '0;
      bit_cnt            <= '0;
      spawn.spawn_valid  <= 1'b0;
      spawn.spawn_x      <= '0;
      spawn.spawn_xspeed <= '0;
      spawn.spawn_yspeed <= '0;
      spawn.spawn_sign   <= 1'b0;
      spawn_count        <= '0;
      miss_count         <= '0;
    end else begin
      if (do_shift) begin
        sr      <= {sr[15:0], random_bit};
        bit_cnt <= bit_cnt + 5'd1;
      end else if (do_clr) begin
        bit_cnt <= '0;
      end
      if (do_latch) begin
        spawn.spawn_valid  <= 1'b1;
        spawn.spawn_x      <= x_map;
        spawn.spawn_xspeed <= xs_map;
        spawn.spawn_yspeed <= ys_map;
        spawn.spawn_sign   <= sr[0];
      end else if (do_accept) begin
        spawn.spawn_valid <= 1'b0;
      end
      if (do_accept) spawn_count <= spawn_count + 8'd1;
      if (do_miss && miss_count != 8'hFF) miss_count <= miss_count + 8'd1;
    end
  end

endmodule
